// File: rtl/user_frame_tx.sv
// user_frame_tx: user-side initiator that packs op/data into an authenticated
// frame, pulses start, holds the frame until the operation completes; USER_TX_RETRY_EN enables retries.
module user_frame_tx #(
  parameter logic [2:0] USER_ID      = 3'b101,
  parameter int         AUTH_TIMEOUT = 4,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_data,
  output logic        start,
  output logic [15:0] frame,
  input  logic        auth_done,
  input  logic        op_done,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_err
);

  localparam int TW = (AUTH_TIMEOUT < 2) ? 1 : $clog2(AUTH_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(AUTH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_AUTH,
    S_WAIT_OP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   frame_q, frame_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    onehot;
  logic          last_try;

`ifdef USER_TX_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  logic [RW-1:0] rcnt_q, rcnt_d;

  assign last_try = (rcnt_q == R_MAX);

  // Retry counter: attempts already repeated for the current request
  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end
`else
  // Without retries every failed attempt is the final one
  assign last_try = (MAX_RETRY >= 0);
`endif

  // Op select to the one-hot opcode field the server decodes
  always_comb begin
    onehot = 4'b0001;
    unique case (req_op)
      2'b00: onehot = 4'b0001;
      2'b01: onehot = 4'b0010;
      2'b11: onehot = 4'b0100;
      2'b10: onehot = 4'b1000;
      default: onehot = 4'b0001;
    endcase
  end

  // State, frame and timeout counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic; frame is cleared whenever a request ends
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tcnt_d  = tcnt_q;
`ifdef USER_TX_RETRY_EN
    rcnt_d  = rcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        frame_d = '0;
        if (req_valid) begin
          frame_d = {1'b0, USER_ID, onehot, req_data};
`ifdef USER_TX_RETRY_EN
          rcnt_d  = '0;
`endif
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tcnt_d  = '0;
        state_d = S_WAIT_AUTH;
      end
      S_WAIT_AUTH: begin
        tcnt_d = tcnt_q + 1'b1;
        if (auth_done) begin
          state_d = S_WAIT_OP;
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_FAIL;
          if (last_try) frame_d = '0;
        end
      end
      S_WAIT_OP: begin
        if (op_done) begin
          state_d = S_DONE;
          frame_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
`ifdef USER_TX_RETRY_EN
        if (!last_try) begin
          rcnt_d  = rcnt_q + 1'b1;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        frame_d = '0;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign start     = (state_q == S_SEND);
  assign tx_done   = (state_q == S_DONE);
  assign tx_err    = (state_q == S_FAIL) && last_try;
  assign frame     = frame_q;

endmodule

// File: tb/tb_user_frame_tx.sv
// tb_user_frame_tx: scoreboard bench for user_frame_tx with a simple
// server model that answers auth/op after programmable delays.
module tb_user_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_data;
  logic        start;
  logic [15:0] frame;
  logic        auth_done;
  logic        op_done;
  logic        busy;
  logic        tx_done;
  logic        tx_err;

  user_frame_tx dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .start     (start),
    .frame     (frame),
    .auth_done (auth_done),
    .op_done   (op_done),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op,
                                     input logic [7:0] d);
    logic [3:0] oh;
    case (op)
      2'b00: oh = 4'h1;
      2'b01: oh = 4'h2;
      2'b11: oh = 4'h4;
      default: oh = 4'h8;
    endcase
    return {1'b0, 3'b101, oh, d};
  endfunction

  // scoreboard and event bookkeeping
  logic [15:0] exp_q[$];
  int          scyc[$];
  int          hs_cnt = 0, hs_cyc = 0;
  int          start_cnt = 0, start_cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          err_cnt = 0, err_cyc = 0;
  logic [15:0] start_frame = '0;
  logic        prev_start = 1'b0;

  // server model: delays counted in cycles after the start cycle
  int auth_t = 1;
  int op_t = 2;
  int t = -1;

  initial begin
    auth_done = 1'b0;
    op_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) t = -1;
      else if (start) t = 0;
      else if (t >= 0) t++;
      auth_done = (t >= 0) && (t == auth_t);
      op_done   = (t >= 0) && (t == op_t);
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          exp_q.push_back(mk(req_op, req_data));
          hs_cnt++;
          hs_cyc = cyc;
        end
        if (start) begin
          chk("start_b2b", {31'b0, prev_start}, 0);
          start_cnt++;
          start_cyc = cyc;
          start_frame = frame;
          scyc.push_back(cyc);
          if (exp_q.size() > 0) chk("start_frame", frame, exp_q[0]);
          else chk("start_noexp", exp_q.size(), 1);
        end else if (busy && !tx_done && !tx_err && exp_q.size() > 0) begin
          chk("frame_hold", frame, exp_q[0]);
        end
        if (tx_done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_q", exp_q.size(), 1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (tx_err) begin
          err_cnt++;
          err_cyc = cyc;
          chk("err_q", exp_q.size(), 1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        prev_start = start;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int h0 = hs_cnt;
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    while (hs_cnt == h0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("hs_seen", hs_cnt - h0, 1);
  endtask

  task automatic wait_end(input int maxc);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("end_seen", (done_cnt - d0) + (err_cnt - e0), 1);
  endtask

  logic [1:0] op_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [3:0] oh_tab[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0] d_tab[4]  = '{8'h00, 8'h5A, 8'hFF, 8'h81};

  initial begin
    int s0, d0, e0, h0, n, exp_starts;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame, 0);
    chk("rst_pulses", {start, tx_done, tx_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic transfer, op_done three cycles after auth
    auth_t = 1; op_t = 4;
    s0 = start_cnt;
    issue(2'b01, 8'hA5);
    wait_end(40);
    chk("t1_frame", start_frame, 16'h52A5);
    chk("t1_start_lat", start_cyc - hs_cyc, 1);
    chk("t1_done_lat", done_cyc - hs_cyc, 6);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_ready", req_ready, 1);

    // 2: op to one-hot mapping
    auth_t = 1; op_t = 2;
    for (int i = 0; i < 4; i++) begin
      issue(op_tab[i], d_tab[i]);
      wait_end(40);
      chk("t2_onehot", start_frame[11:8], oh_tab[i]);
      chk("t2_hdr", start_frame[15:12], 4'h5);
    end

    // 3: authentication never arrives
    auth_t = -1; op_t = -1;
    s0 = start_cnt;
    e0 = err_cnt;
    scyc.delete();
`ifdef USER_TX_RETRY_EN
    exp_starts = 4;
`else
    exp_starts = 1;
`endif
    issue(2'b10, 8'h3C);
    wait_end(80);
    chk("t3_starts", start_cnt - s0, exp_starts);
    chk("t3_err", err_cnt - e0, 1);
    for (int i = 1; i < scyc.size(); i++)
      chk("t3_spacing", scyc[i] - scyc[i-1], 6);
    chk("t3_err_lat", err_cyc - start_cyc, 5);
    chk("t3_ready", req_ready, 1);

    // 4: auth_done on the timeout-expiry cycle wins
    auth_t = 4; op_t = 6;
    s0 = start_cnt;
    e0 = err_cnt;
    d0 = done_cnt;
    issue(2'b11, 8'h77);
    wait_end(40);
    chk("t4_starts", start_cnt - s0, 1);
    chk("t4_err", err_cnt - e0, 0);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_done_lat", done_cyc - start_cyc, 7);

    // 5: reset while waiting for the operation
    auth_t = 1; op_t = -1;
    issue(2'b00, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_pre", busy, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_frame", frame, 0);
    chk("t5_start", start, 0);
    chk("t5_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    exp_q.delete();

    // 6: req_valid held high across two back-to-back requests
    auth_t = 1; op_t = 3;
    s0 = start_cnt;
    h0 = hs_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op = 2'b11;
    req_data = 8'hC3;
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_op = 2'b01;
    req_data = 8'h96;
    n = 0;
    while (hs_cnt < h0 + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("t6_hs", hs_cnt - h0, 2);
    chk("t6_second_hs", hs_cyc - done_cyc, 1);
    wait_end(40);
    chk("t6_starts", start_cnt - s0, 2);
    chk("t6_last_frame", start_frame, 16'h5296);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
